// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the system reset for the PLL output domain. Retries on lock
// timeout, parks in FAULT once the retries are exhausted, and counts lock
// losses seen while running.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 7
) (
    input  logic       in_clk25,
    input  logic       in_resetn,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_resetn,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic       fault
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    // One shared counter; sized for the longest interval it has to time.
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic [1:0]       sync_ff;
    logic             locked_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       nxt_state;
    logic [3:0]       nxt_retry;
    logic [7:0]       nxt_loss;
    logic             cnt_clr;

    assign locked_s = sync_ff[1];

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge in_clk25) begin
        if (!in_resetn) sync_ff <= 2'b00;
        else            sync_ff <= {sync_ff[0], pll_locked};
    end

    // Next-state, retry and lock-loss decisions; restart overrides the FSM
    // but a lock loss detected on the same cycle is still counted.
    always_comb begin
        nxt_state = state;
        nxt_retry = retry_cnt;
        nxt_loss  = lock_loss_cnt;
        case (state)
            S_RESET_PLL: if (cnt == RST_LAST) nxt_state = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    nxt_state = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        nxt_state = S_FAULT;
                    end else begin
                        nxt_state = S_RESET_PLL;
                        nxt_retry = retry_cnt + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    nxt_state = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    nxt_state = S_RUN;
                    nxt_retry = 4'd0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    nxt_state = S_WAIT_LOCK;
                    if (lock_loss_cnt != 8'hFF) nxt_loss = lock_loss_cnt + 8'd1;
                end
            end
            S_FAULT: nxt_state = S_FAULT;
            default: nxt_state = S_RESET_PLL;
        endcase
        if (restart_req) begin
            nxt_state = S_RESET_PLL;
            nxt_retry = 4'd0;
        end
    end

    // A restart re-arms the count even when already in RESET_PLL.
    assign cnt_clr = restart_req || (nxt_state != state);

    // State, counter and registered outputs all update together.
    always_ff @(posedge in_clk25) begin
        if (!in_resetn) begin
            state         <= S_RESET_PLL;
            cnt           <= '0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            sys_resetn    <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= nxt_state;
            retry_cnt     <= nxt_retry;
            lock_loss_cnt <= nxt_loss;
            pll_rst       <= (nxt_state == S_RESET_PLL);
            sys_resetn    <= (nxt_state == S_RUN);
            fault         <= (nxt_state == S_FAULT);
            if (cnt_clr)
                cnt <= '0;
            else if (state == S_RESET_PLL || state == S_WAIT_LOCK || state == S_STABLE)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic       in_clk25 = 1'b0;
    logic       in_resetn;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       sys_resetn;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic       fault;

    int checks   = 0;
    int failures = 0;
    int n;
    int bad;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES    (4),
        .LOCK_TIMEOUT      (32),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (2)
    ) dut (
        .in_clk25     (in_clk25),
        .in_resetn    (in_resetn),
        .pll_locked   (pll_locked),
        .restart_req  (restart_req),
        .pll_rst      (pll_rst),
        .sys_resetn   (sys_resetn),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt),
        .fault        (fault)
    );

    always #5 in_clk25 = ~in_clk25;

    task automatic tick();
        @(posedge in_clk25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_val(input int sel);
        case (sel)
            0:       return 32'(pll_rst);
            1:       return 32'(sys_resetn);
            default: return 32'(state);
        endcase
    endfunction

    // Ticks until the selected output equals val; n = edges taken, max+1 on timeout.
    task automatic wait_until(input int sel, input int val, input int max, output int cnt_o);
        cnt_o = max + 1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (sel_val(sel) == 32'(val)) begin
                cnt_o = i;
                return;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_sys_resetn"}, 32'(sys_resetn), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_loss"}, 32'(lock_loss_cnt), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
    endtask

    initial begin
        in_resetn = 1'b0; pll_locked = 1'b0; restart_req = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        // First bring-up.
        in_resetn = 1'b1;
        wait_until(0, 0, 20, n);
        chk("first_pulse_len", n, 4);
        chk("first_wait_state", 32'(state), 1);
        pll_locked = 1'b1;
        wait_until(1, 1, 40, n);
        chk("bringup_edges", n, 11);
        chk("bringup_state", 32'(state), 3);
        chk("bringup_retry", 32'(retry_cnt), 0);

        // Lock never arrives: retries then FAULT.
        pll_locked = 1'b0; restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("restart_state", 32'(state), 0);
        chk("restart_no_loss", 32'(lock_loss_cnt), 0);
        wait_until(0, 0, 20, n);  chk("pulse0_len", n, 4);
        wait_until(0, 1, 60, n);  chk("timeout0_len", n, 32);
        chk("retry_1", 32'(retry_cnt), 1);
        wait_until(0, 0, 20, n);  chk("pulse1_len", n, 4);
        wait_until(0, 1, 60, n);  chk("timeout1_len", n, 32);
        chk("retry_2", 32'(retry_cnt), 2);
        wait_until(0, 0, 20, n);  chk("pulse2_len", n, 4);
        wait_until(2, 4, 60, n);  chk("timeout2_len", n, 32);
        chk("fault_flag", 32'(fault), 1);
        chk("fault_pll_rst", 32'(pll_rst), 0);
        chk("fault_sys_resetn", 32'(sys_resetn), 0);
        chk("fault_retry", 32'(retry_cnt), 2);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 1'b0) bad++;
        end
        chk("fault_hold_bad_cycles", bad, 0);

        // Restart out of FAULT, then normal bring-up.
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0; pll_locked = 1'b1;
        chk("fault_exit_state", 32'(state), 0);
        chk("fault_exit_retry", 32'(retry_cnt), 0);
        chk("fault_exit_fault", 32'(fault), 0);
        chk("fault_exit_pll_rst", 32'(pll_rst), 1);
        wait_until(0, 0, 20, n);  chk("fault_exit_pulse", n, 4);
        wait_until(1, 1, 40, n);  chk("fault_exit_to_run", n, 9);
        chk("fault_exit_run_state", 32'(state), 3);

        // Glitch during STABLE restarts the stability window.
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        wait_until(0, 0, 20, n);  chk("glitch_pulse", n, 4);
        tick();
        chk("glitch_in_stable", 32'(state), 2);
        tick(); tick();
        pll_locked = 1'b0;
        tick(); tick();
        pll_locked = 1'b1;
        chk("glitch_still_stable", 32'(state), 2);
        tick();
        chk("glitch_to_wait", 32'(state), 1);
        chk("glitch_sysrst_low", 32'(sys_resetn), 0);
        tick();
        chk("glitch_wait2", 32'(state), 1);
        tick();
        chk("glitch_restable", 32'(state), 2);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (sys_resetn !== 1'b0 || state !== 3'd2) bad++;
        end
        chk("glitch_window_bad", bad, 0);
        tick();
        chk("glitch_run", 32'(state), 3);
        chk("glitch_run_sysrst", 32'(sys_resetn), 1);
        chk("glitch_retry", 32'(retry_cnt), 0);

        // 300 lock losses in RUN; counter saturates.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_until(1, 0, 10, n);
            chk("loss_fall_edges", n, 3);
            chk("loss_count", 32'(lock_loss_cnt), (i + 1 > 255) ? 255 : i + 1);
            pll_locked = 1'b1;
            wait_until(2, 3, 40, n);
            chk("relock_edges", n, 11);
            chk("relock_retry", 32'(retry_cnt), 0);
        end

        // Reset asserted during STABLE.
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        wait_until(0, 0, 20, n);
        tick();
        chk("pre_reset_stable", 32'(state), 2);
        tick(); tick();
        in_resetn = 1'b0;
        tick();
        chk_reset_vals("mid_reset");
        in_resetn = 1'b1;
        wait_until(0, 0, 20, n);  chk("post_reset_pulse", n, 4);
        wait_until(1, 1, 40, n);  chk("post_reset_to_run", n, 9);

        // Restart coinciding with lock-loss detection.
        pll_locked = 1'b0;
        tick(); tick();
        chk("coincide_pre_run", 32'(state), 3);
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("coincide_state", 32'(state), 0);
        chk("coincide_loss", 32'(lock_loss_cnt), 1);
        chk("coincide_pll_rst", 32'(pll_rst), 1);
        chk("coincide_sys_resetn", 32'(sys_resetn), 0);

        // Restart while already pulsing restarts the pulse count.
        tick(); tick();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        wait_until(0, 0, 20, n);  chk("repulse_len", n, 4);
        chk("repulse_wait_state", 32'(state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse (minimum 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry (minimum 2).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive locked cycles required before system reset release (minimum 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 7: PLL reset retries allowed before FAULT (range 0..15).
REQ-005 SHALL have port in_clk25, input, 1 bit: 25 MHz reference clock, the only clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port in_resetn, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL LOCK output; asynchronous to in_clk25.
REQ-008 SHALL have port restart_req, input, 1 bit: single-cycle soft restart request, synchronous to in_clk25.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives the PLL RST pin; active high.
REQ-010 SHALL have port sys_resetn, output, 1 bit: active-low reset for logic in the PLL output domain.
REQ-011 SHALL have port state, output, 3 bits: 0=RESET_PLL, 1=WAIT_LOCK, 2=STABLE, 3=RUN, 4=FAULT.
REQ-012 SHALL have port retry_cnt, output, 4 bits: retries used since the last RUN entry or restart.
REQ-013 SHALL have port lock_loss_cnt, output, 8 bits: number of lock losses while in RUN; saturates at 255.
REQ-014 SHALL have port fault, output, 1 bit: high exactly while state is FAULT.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; the FSM uses only the second flop's output (locked_s).
REQ-016 All outputs SHALL be registered; pll_rst is high only in RESET_PLL; sys_resetn is high only in RUN; both update on the same edge as state.
REQ-017 A single cycle counter (at least 17 bits at default parameters) SHALL be cleared on every state change.
REQ-018 RESET_PLL: after PLL_RST_CYCLES cycles in this state, the FSM SHALL go to WAIT_LOCK.
REQ-019 WAIT_LOCK, locked_s=1: the FSM SHALL go to STABLE.
REQ-020 WAIT_LOCK, locked_s=0 for LOCK_TIMEOUT cycles: if retry_cnt==MAX_RETRIES, go to FAULT; otherwise increment retry_cnt and go to RESET_PLL.
REQ-021 STABLE, locked_s=0: the FSM SHALL go to WAIT_LOCK (timeout restarts from 0; retry_cnt unchanged).
REQ-022 STABLE, locked_s=1 for LOCK_STABLE_CYCLES consecutive cycles: go to RUN and clear retry_cnt.
REQ-023 RUN, locked_s=0: go to WAIT_LOCK, deassert sys_resetn on that edge, and increment lock_loss_cnt (saturating at 255).
REQ-024 FAULT SHALL hold pll_rst=0, sys_resetn=0 and fault=1 until restart_req or reset.
REQ-025 restart_req=1 SHALL take priority over all transitions in every state: go to RESET_PLL, clear retry_cnt, keep lock_loss_cnt, and restart the pulse count even if already in RESET_PLL.
REQ-026 A lock-loss detection in RUN that coincides with restart_req SHALL still increment lock_loss_cnt; the next state SHALL be RESET_PLL.
REQ-027 Latency: pll_locked rising, first sampled at edge k, gives locked_s=1 after edge k+1, STABLE after edge k+2, and RUN/sys_resetn=1 after edge k+2+LOCK_STABLE_CYCLES, provided lock holds.

Reset
REQ-028 in_resetn=0 at a rising edge SHALL set state=RESET_PLL, pll_rst=1, sys_resetn=0, counter=0, retry_cnt=0, lock_loss_cnt=0, fault=0, and both synchronizer flops to 0.
REQ-029 In-reset behaviour SHALL override restart_req and pll_locked; reset asserted mid-operation (any state) SHALL take effect on the next edge.
REQ-030 After reset release, the first pll_rst pulse SHALL last exactly PLL_RST_CYCLES cycles.

Verification (bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 Release reset; pll_locked goes high after pll_rst falls -> pll_rst high for exactly 4 cycles; sys_resetn rises 10 edges after the first edge sampling pll_locked=1; retry_cnt=0.
REQ-032 pll_locked held 0 -> three pll_rst pulses of 4 cycles, spaced by 32 WAIT_LOCK cycles; retry_cnt goes 1 then 2; then state=4, fault=1, pll_rst=0; the bench checks it stays there for 100 cycles.
REQ-033 In FAULT, pulse restart_req, then assert pll_locked -> RESET_PLL with retry_cnt=0, followed by normal bring-up to RUN.
REQ-034 pll_locked glitches low for 2 cycles during STABLE -> back to WAIT_LOCK; STABLE restarts, and RUN is reached only after 8 clean consecutive cycles; sys_resetn stays 0 throughout.
REQ-035 In RUN, drop pll_locked 300 times -> sys_resetn falls 2 edges after each drop; lock_loss_cnt saturates at 255; on each relock, RUN is reentered with retry_cnt=0.
REQ-036 restart_req on the same cycle a lock loss is detected in RUN -> next state=RESET_PLL and lock_loss_cnt increments by 1; in_resetn=0 during STABLE -> all REQ-028 values on the next edge.
